// File: rtl/flit_sink_monitor_pkg.sv
// Shared definitions for the flit sink monitor: flit type encodings and FSM state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package flit_sink_monitor_pkg;

  // Width of the flit type field carried in the MSBs of every flit.
  localparam int FLIT_TYPEW = 2;

  typedef enum logic [FLIT_TYPEW-1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_e;

endpackage

// File: rtl/flit_sink_monitor_popcnt.sv
// Purpose: combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: vec_i [W-1:0] vector to count; cnt_o [$clog2(W):0] number of set bits.
module flitmon_popcnt #(
  parameter int W = 66
) (
  input  logic [W-1:0]        vec_i,
  output logic [$clog2(W):0]  cnt_o
);

  localparam int CW = $clog2(W) + 1;

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/flit_sink_monitor.sv
// Purpose: terminal flit receiver; checks head/data/tail framing, counts packets/flits, accumulates bus toggles.
// Latency: all outputs registered, visible 1 cycle after the flit/cycle is sampled.
// Backpressure: none; always accepts, every valid flit is consumed in the cycle it is presented.
// Ports: clk, rst (sync, active-high) | idata/ivalid/ivch flit input | ien measurement window | clr counter clear
//        busy (packet open) | pkt_cnt, flit_cnt, tgl_cnt, last_len statistics | err_orph/nest/vch/len sticky flags
// Option: define FLITMON_LENCHK_EN to enable the over-length check driving err_len (else err_len is 0).
module flit_sink_monitor
  import flit_sink_monitor_pkg::*;
#(
  parameter int DATAW_P1 = 66,
  parameter int TYPEW    = FLIT_TYPEW,
  parameter int VCHW_P1  = 2,
  parameter int CNTW     = 32,
  parameter int MAX_LEN  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATAW_P1-1:0] idata,
  input  logic                ivalid,
  input  logic [VCHW_P1-1:0]  ivch,
  input  logic                ien,
  input  logic                clr,
  output logic                busy,
  output logic [CNTW-1:0]     pkt_cnt,
  output logic [CNTW-1:0]     flit_cnt,
  output logic [CNTW-1:0]     tgl_cnt,
  output logic [CNTW-1:0]     last_len,
  output logic                err_orph,
  output logic                err_nest,
  output logic                err_vch,
  output logic                err_len
);

  localparam int PCW = $clog2(DATAW_P1) + 1;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cur_len_q, cur_len_d;
  logic [VCHW_P1-1:0]    cur_vch_q, cur_vch_d;
  logic [DATAW_P1-1:0]   prev_q;
  logic [CNTW-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [CNTW-1:0]       flit_cnt_q, flit_cnt_d;
  logic [CNTW-1:0]       tgl_cnt_q, tgl_cnt_d;
  logic [CNTW-1:0]       last_len_q, last_len_d;
  logic                  err_orph_q, err_orph_d;
  logic                  err_nest_q, err_nest_d;
  logic                  err_vch_q, err_vch_d;

  flit_type_e            ftype;
  logic                  vld_flit;
  logic [CNTW-1:0]       len_inc;
  logic [PCW-1:0]        tgl_now;
  logic [CNTW:0]         tgl_sum;
  logic                  orph, nest, vch_mis, tail_done;

  flitmon_popcnt #(.W(DATAW_P1)) u_popcnt (
    .vec_i (idata ^ prev_q),
    .cnt_o (tgl_now)
  );

  assign ftype    = flit_type_e'(idata[DATAW_P1-1 -: TYPEW]);
  assign vld_flit = ivalid && (ftype != TYPE_NONE);
  assign len_inc  = sat_inc(cur_len_q);
  assign tgl_sum  = {1'b0, tgl_cnt_q} + (CNTW+1)'(tgl_now);
  assign vch_mis  = vld_flit && (state_q == ST_BODY) && (ivch != cur_vch_q);

`ifdef FLITMON_LENCHK_EN
  logic err_len_q, err_len_d;
  logic len_over;
  // Head restarts the count, so only continuation flits can push a packet past the limit.
  assign len_over = vld_flit && (state_q == ST_BODY) && (ftype != TYPE_HEAD)
                    && (len_inc > CNTW'(MAX_LEN));
  assign err_len  = err_len_q;
`else
  // MAX_LEN only matters when the length check is built in.
  logic maxlen_unused;
  assign maxlen_unused = (MAX_LEN != 0);
  assign err_len       = 1'b0;
`endif

  // Framing FSM and length/vch tracking run independently of ien and clr.
  always_comb begin
    state_d   = state_q;
    cur_len_d = cur_len_q;
    cur_vch_d = cur_vch_q;
    orph      = 1'b0;
    nest      = 1'b0;
    tail_done = 1'b0;
    if (vld_flit) begin
      case (state_q)
        ST_IDLE: begin
          if (ftype == TYPE_HEAD) begin
            state_d   = ST_BODY;
            cur_len_d = CNTW'(1);
            cur_vch_d = ivch;
          end else begin
            orph = 1'b1;
          end
        end
        ST_BODY: begin
          case (ftype)
            TYPE_HEAD: begin
              nest      = 1'b1;
              cur_len_d = CNTW'(1);
              cur_vch_d = ivch;
            end
            TYPE_DATA: cur_len_d = len_inc;
            TYPE_TAIL: begin
              state_d   = ST_IDLE;
              cur_len_d = '0;
              tail_done = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Statistics: clr beats any same-cycle update; otherwise gated by the measurement window.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    tgl_cnt_d  = tgl_cnt_q;
    last_len_d = last_len_q;
    err_orph_d = err_orph_q;
    err_nest_d = err_nest_q;
    err_vch_d  = err_vch_q;
`ifdef FLITMON_LENCHK_EN
    err_len_d  = err_len_q;
`endif
    if (clr) begin
      pkt_cnt_d  = '0;
      flit_cnt_d = '0;
      tgl_cnt_d  = '0;
      last_len_d = '0;
      err_orph_d = 1'b0;
      err_nest_d = 1'b0;
      err_vch_d  = 1'b0;
`ifdef FLITMON_LENCHK_EN
      err_len_d  = 1'b0;
`endif
    end else if (ien) begin
      if (vld_flit) flit_cnt_d = sat_inc(flit_cnt_q);
      if (tail_done) begin
        pkt_cnt_d  = sat_inc(pkt_cnt_q);
        last_len_d = len_inc;
      end
      tgl_cnt_d  = tgl_sum[CNTW] ? '1 : tgl_sum[CNTW-1:0];
      err_orph_d = err_orph_q | orph;
      err_nest_d = err_nest_q | nest;
      err_vch_d  = err_vch_q  | vch_mis;
`ifdef FLITMON_LENCHK_EN
      err_len_d  = err_len_q  | len_over;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_len_q  <= '0;
      cur_vch_q  <= '0;
      prev_q     <= '0;
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
      tgl_cnt_q  <= '0;
      last_len_q <= '0;
      err_orph_q <= 1'b0;
      err_nest_q <= 1'b0;
      err_vch_q  <= 1'b0;
`ifdef FLITMON_LENCHK_EN
      err_len_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_len_q  <= cur_len_d;
      cur_vch_q  <= cur_vch_d;
      // Tracked every cycle so the first in-window cycle compares against the true previous flit.
      prev_q     <= idata;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
      tgl_cnt_q  <= tgl_cnt_d;
      last_len_q <= last_len_d;
      err_orph_q <= err_orph_d;
      err_nest_q <= err_nest_d;
      err_vch_q  <= err_vch_d;
`ifdef FLITMON_LENCHK_EN
      err_len_q  <= err_len_d;
`endif
    end
  end

  assign busy     = (state_q == ST_BODY);
  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;
  assign tgl_cnt  = tgl_cnt_q;
  assign last_len = last_len_q;
  assign err_orph = err_orph_q;
  assign err_nest = err_nest_q;
  assign err_vch  = err_vch_q;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed bench for flit_sink_monitor: framing, counters, toggle accounting, clear/reset priority.
// Latency: checks sample outputs 1 ns after the edge that captured the stimulus.
// Backpressure: n/a (the monitor never stalls its input).
module tb_flit_sink_monitor;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] idata;
  logic        ivalid;
  logic [1:0]  ivch;
  logic        ien;
  logic        clr;
  logic        busy;
  logic [31:0] pkt_cnt, flit_cnt, tgl_cnt, last_len;
  logic        err_orph, err_nest, err_vch, err_len;

  int vectors = 0;
  int miscompares = 0;
  logic exp_len_err;

  flit_sink_monitor #(
    .DATAW_P1 (66),
    .TYPEW    (2),
    .VCHW_P1  (2),
    .CNTW     (32),
    .MAX_LEN  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .idata    (idata),
    .ivalid   (ivalid),
    .ivch     (ivch),
    .ien      (ien),
    .clr      (clr),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt),
    .flit_cnt (flit_cnt),
    .tgl_cnt  (tgl_cnt),
    .last_len (last_len),
    .err_orph (err_orph),
    .err_nest (err_nest),
    .err_vch  (err_vch),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [1:0] vch, input logic [63:0] pl);
    idata  = {t, pl};
    ivch   = vch;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
`ifdef FLITMON_LENCHK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    rst = 1'b1; idata = '0; ivalid = 1'b0; ivch = '0; ien = 1'b0; clr = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_flit", flit_cnt, 0);
    chk("rst_tgl", tgl_cnt, 0);
    chk("rst_last", last_len, 0);
    chk("rst_errs", {28'd0, err_orph, err_nest, err_vch, err_len}, 0);
    rst = 1'b0;
    ien = 1'b1;

    // 1) clean 22-flit packet on vch 0
    send(T_HEAD, 2'd0, 64'h0);
    chk("t1_busy_head", 32'(busy), 1);
    for (int i = 0; i < 20; i++) send(T_DATA, 2'd0, 64'(i * 64'h0101_0101));
    send(T_TAIL, 2'd0, 64'hdead_beef);
    tick();
    chk("t1_pkt", pkt_cnt, 1);
    chk("t1_flit", flit_cnt, 22);
    chk("t1_last", last_len, 22);
    chk("t1_errs", {29'd0, err_orph, err_nest, err_vch}, 0);
    chk("t1_busy_after", 32'(busy), 0);

    // 2) toggle accounting: clr cycle drives idata=0 so prev is 0, clr wins over that cycle's toggles
    idata = '0;
    do_clr();
    chk("t2_clr_tgl", tgl_cnt, 0);
    chk("t2_clr_flit", flit_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      idata = (i % 2 == 0) ? {66{1'b1}} : 66'd0;
      tick();
    end
    ien = 1'b0;
    chk("t2_tgl660", tgl_cnt, 660);
    idata = {66{1'b1}};
    tick();
    chk("t2_tgl_gated", tgl_cnt, 660);
    ien = 1'b1;
    idata = '0;
    tick();
    chk("t2_tgl_prev_tracked", tgl_cnt, 726);
    chk("t2_no_flits", flit_cnt, 0);

    // 3) orphan tail, nested head
    do_clr();
    send(T_TAIL, 2'd0, 64'h1);
    send(T_HEAD, 2'd0, 64'h2);
    send(T_HEAD, 2'd0, 64'h3);
    send(T_TAIL, 2'd0, 64'h4);
    tick();
    chk("t3_orph", 32'(err_orph), 1);
    chk("t3_nest", 32'(err_nest), 1);
    chk("t3_vch", 32'(err_vch), 0);
    chk("t3_pkt", pkt_cnt, 1);
    chk("t3_last", last_len, 2);
    chk("t3_flit", flit_cnt, 4);
    do_clr();
    chk("t3_clr_errs", {30'd0, err_orph, err_nest}, 0);

    // 4) vch change inside packet, ivalid gaps
    send(T_HEAD, 2'd1, 64'h10);
    tick();
    send(T_DATA, 2'd2, 64'h11);
    tick();
    tick();
    send(T_TAIL, 2'd1, 64'h12);
    tick();
    chk("t4_vch", 32'(err_vch), 1);
    chk("t4_pkt", pkt_cnt, 1);
    chk("t4_last", last_len, 3);
    chk("t4_flit", flit_cnt, 3);
    chk("t4_nest", 32'(err_nest), 0);

    // 5) length limit 8: 9th flit is the first over-length one
    do_clr();
    send(T_HEAD, 2'd0, 64'h20);
    for (int i = 0; i < 7; i++) send(T_DATA, 2'd0, 64'(i));
    chk("t5_len_at_max", 32'(err_len), 0);
    send(T_DATA, 2'd0, 64'h7);
    chk("t5_len_over", 32'(err_len), 32'(exp_len_err));
    send(T_TAIL, 2'd0, 64'h21);
    tick();
    chk("t5_last", last_len, 10);
    chk("t5_pkt", pkt_cnt, 1);

    // 6) reset mid-packet drops it; tail afterwards is an orphan
    do_clr();
    send(T_HEAD, 2'd0, 64'h30);
    for (int i = 0; i < 3; i++) send(T_DATA, 2'd0, 64'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_flit", flit_cnt, 0);
    chk("t6_rst_tgl", tgl_cnt, 0);
    send(T_TAIL, 2'd0, 64'h31);
    tick();
    chk("t6_orph", 32'(err_orph), 1);
    chk("t6_pkt", pkt_cnt, 0);
    chk("t6_flit", flit_cnt, 1);

    // clr coinciding with the tail: counters cleared, FSM still closes the packet
    send(T_HEAD, 2'd0, 64'h40);
    send(T_DATA, 2'd0, 64'h41);
    clr = 1'b1;
    send(T_TAIL, 2'd0, 64'h42);
    clr = 1'b0;
    chk("t6_clr_pkt", pkt_cnt, 0);
    chk("t6_clr_last", last_len, 0);
    chk("t6_clr_busy", 32'(busy), 0);
    send(T_HEAD, 2'd0, 64'h43);
    send(T_TAIL, 2'd0, 64'h44);
    chk("t6_after_pkt", pkt_cnt, 1);
    chk("t6_after_last", last_len, 2);
    chk("t6_after_orph", 32'(err_orph), 0);

    // FSM tracks length outside the window, counters do not
    do_clr();
    ien = 1'b0;
    send(T_HEAD, 2'd0, 64'h50);
    ien = 1'b1;
    send(T_DATA, 2'd0, 64'h51);
    send(T_TAIL, 2'd0, 64'h52);
    chk("t7_pkt", pkt_cnt, 1);
    chk("t7_last", last_len, 3);
    chk("t7_flit", flit_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
